// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - instruction bus between the fetch sequencer and instruction memory
//
// Signals:
//   ibus_req_o    fetch request (master -> slave)
//   ibus_addr_o   fetch address, held stable while a request waits for ack
//   ibus_ack_i    transfer completion; rdata and err are valid in this cycle
//   ibus_rdata_i  instruction word
//   ibus_err_i    bus error, qualified by ack
interface if_fetch_ctrl_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic        ibus_err_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_rdata_i,
        input  ibus_err_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_rdata_i,
        output ibus_err_i
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch sequencer between the PC register and the instruction bus
//
// Ports:
//   clk, rst       clock; asynchronous active-low reset
//   ce_i           PC chip-enable, 0 forces the sequencer idle
//   pc_i           current PC
//   flush_i        pipeline flush, the PC reloads on this edge
//   stall_i        downstream stall, IF/ID is not latching
//   stallreq_o     hold the PC while a fetch is outstanding
//   ibus           instruction bus (master side)
//   inst_o         instruction to IF/ID
//   inst_valid_o   inst_o valid this cycle
//   fetch_err_o    one-cycle fetch failure (bus error or timeout)
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h3000_0000,
    parameter int          TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           pc_i,
    input  logic                  flush_i,
    input  logic                  stall_i,
    output logic                  stallreq_o,
    if_fetch_ctrl_if.master       ibus,
    output logic [31:0]           inst_o,
    output logic                  inst_valid_o,
    output logic                  fetch_err_o
);

    localparam int                WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_err_q, hold_err_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;

    logic               timed_out;
    logic [WCNT_W-1:0]  wcnt_inc;
    logic [31:0]        fetched;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= RESET_ADDR;
            hold_q     <= '0;
            hold_err_q <= 1'b0;
            wcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            hold_err_q <= hold_err_d;
            wcnt_q     <= wcnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        hold_d           = hold_q;
        hold_err_d       = hold_err_q;
        wcnt_d           = wcnt_q;
        stallreq_o       = 1'b0;
        ibus.ibus_req_o  = 1'b0;
        ibus.ibus_addr_o = addr_q;
        inst_o           = '0;
        inst_valid_o     = 1'b0;
        fetch_err_o      = 1'b0;

        timed_out = (wcnt_q == WCNT_LAST) && !ibus.ibus_ack_i;
        // Saturate so a stuck slave can never wrap the counter back past the limit.
        wcnt_inc  = (wcnt_q == WCNT_LAST) ? wcnt_q : wcnt_q + 1'b1;
        // An errored word is never forwarded as an instruction.
        fetched   = ibus.ibus_err_i ? 32'h0 : ibus.ibus_rdata_i;

        if (!ce_i) begin
            // Disabling the PC abandons everything, including a same-cycle ack.
            state_d = S_IDLE;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                    wcnt_d  = '0;
                end

                S_REQ: begin
                    ibus.ibus_req_o  = 1'b1;
                    ibus.ibus_addr_o = pc_i;
                    addr_d           = pc_i;
                    stallreq_o       = !ibus.ibus_ack_i;
                    if (ibus.ibus_ack_i) begin
                        wcnt_d = '0;
                        // A flush on the ack cycle kills the word; the new PC is fetched next.
                        if (!flush_i) begin
                            inst_o       = fetched;
                            inst_valid_o = 1'b1;
                            fetch_err_o  = ibus.ibus_err_i;
                            if (stall_i) begin
                                hold_d     = fetched;
                                hold_err_d = ibus.ibus_err_i;
                                state_d    = S_HOLD;
                            end
                        end
                    end else if (timed_out) begin
                        inst_valid_o = 1'b1;
                        fetch_err_o  = 1'b1;
                        stallreq_o   = 1'b0;
                        wcnt_d       = '0;
                        state_d      = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_inc;
                        // The outstanding transfer still has to complete at the old address.
                        if (flush_i) begin
                            state_d = S_DISCARD;
                        end
                    end
                end

                S_HOLD: begin
                    // The PC is already frozen by stall_i; replay the captured word.
                    if (flush_i) begin
                        state_d = S_REQ;
                    end else begin
                        inst_o       = hold_q;
                        inst_valid_o = 1'b1;
                        fetch_err_o  = hold_err_q;
                        if (!stall_i) begin
                            state_d = S_REQ;
                        end
                    end
                end

                S_DISCARD: begin
                    ibus.ibus_req_o = 1'b1;
                    stallreq_o      = 1'b1;
                    if (ibus.ibus_ack_i) begin
                        wcnt_d  = '0;
                        state_d = S_REQ;
                    end else if (timed_out) begin
                        // Nothing was going to be delivered, so no error is reported.
                        stallreq_o = 1'b0;
                        wcnt_d     = '0;
                        state_d    = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_inc;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch sequencer between the PC register and the instruction bus. It issues one fetch per PC value and presents the returned instruction to the IF/ID stage. It raises a stall request so the PC holds while a fetch is outstanding. Flushes and downstream stalls are handled without losing or duplicating instructions, and a wait-state timeout reports a fetch error.

Parameters:
RESET_ADDR, 32'h3000_0000, reset value of the registered fetch address
TIMEOUT, 64, max cycles waiting for ibus_ack_i before the fetch is abandoned (≥2)

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
ce_i  in  1  PC chip-enable; 0 = fetch disabled
pc_i  in  32  current PC
flush_i  in  1  pipeline flush; PC reloads from new_pc this edge
stall_i  in  1  downstream stall (stall[1]); IF/ID is not latching
stallreq_o  out  1  request to hold the PC (drives stall[0] via the stall controller)
ibus_req_o  out  1  bus request
ibus_addr_o  out  32  bus address
ibus_ack_i  in  1  bus completion; rdata and err valid this cycle
ibus_rdata_i  in  32  instruction word
ibus_err_i  in  1  bus error, qualified by ack
inst_o  out  32  instruction to IF/ID
inst_valid_o  out  1  inst_o is valid this cycle
fetch_err_o  out  1  fetch failed (bus error or timeout); one cycle

Behaviour:
- States: IDLE, REQ, HOLD, DISCARD. Registers: state, addr_q[31:0], hold_q[31:0], hold_err_q, wcnt.
- Reset (async, rst=0): state=IDLE, addr_q=RESET_ADDR, hold_q=0, hold_err_q=0, wcnt=0. All outputs are therefore 0, and ibus_addr_o=RESET_ADDR.
- ce_i=0 in any state: next state is IDLE, wcnt=0. Outputs in IDLE are all 0.
- IDLE: ce_i=1 → REQ.
- REQ:
  - ibus_req_o=1, ibus_addr_o=pc_i, addr_q<=pc_i each cycle.
  - stallreq_o = ~ibus_ack_i.
  - On ack with flush_i=0:
    - inst_o = ibus_err_i ? 0 : ibus_rdata_i; inst_valid_o=1; fetch_err_o=ibus_err_i (combinational, same cycle; zero-wait memory sustains 1 instr/cycle).
    - stall_i=0 → stay REQ (next PC fetched next cycle).
    - stall_i=1 → hold_q<=inst_o, hold_err_q<=ibus_err_i, go HOLD.
  - On ack with flush_i=1: inst_valid_o=0, inst_o=0, fetch_err_o=0; stay REQ.
  - No ack with flush_i=1 → DISCARD (the outstanding transfer must complete).
  - wcnt counts cycles without ack and clears on ack.
  - wcnt==TIMEOUT-1 with no ack: fetch_err_o=1, inst_valid_o=1, inst_o=0, stallreq_o=0, ibus_req_o drops next cycle; go IDLE. The bus slave must tolerate the dropped request.
- HOLD:
  - ibus_req_o=0, stallreq_o=0.
  - inst_o=hold_q, inst_valid_o=1, fetch_err_o=hold_err_q.
  - stall_i=0 → REQ.
  - flush_i=1 → REQ; inst_valid_o=0 and fetch_err_o=0 that cycle, hold data dropped.
- DISCARD:
  - ibus_req_o=1, ibus_addr_o=addr_q (stable despite PC reload).
  - stallreq_o=1, inst_valid_o=0, fetch_err_o=0.
  - On ack → REQ; data and error discarded.
  - Further flush_i: stay DISCARD.
  - Timeout applies as in REQ, but the error is suppressed; go IDLE.
- Bus rule: while req=1 and no ack, addr must not change. In REQ this holds because stallreq_o freezes the PC; in DISCARD it holds via addr_q.
- Simultaneous flush_i and stall_i: flush wins.
- Simultaneous ce_i=0 and ack: ack ignored, IDLE.
- wcnt saturates; it does not wrap.

Test Plan:
- Reset and zero-wait: release rst, ce_i=1, ack every cycle from REQ, rdata=pc → inst_o sequence 0x30000000, 0x30000004, …, one per cycle; stallreq_o=0 throughout REQ.
- Wait states: ack 3 cycles after req at pc=0x30000010 → stallreq_o=1 for 3 cycles, addr stable, then inst_valid_o=1 with the correct word.
- Downstream stall: stall_i=1 on ack cycle for 4 cycles → HOLD; inst_o held, ibus_req_o=0; resumes REQ with no duplicate fetch.
- Flush mid-transfer: flush_i at cycle 1 of a 3-cycle wait, new_pc=0x30000100 → DISCARD keeps addr at the old PC, no inst_valid_o, then fetches 0x30000100.
- Bus error: ack with ibus_err_i=1 → inst_o=0, inst_valid_o=1, fetch_err_o=1 for one cycle.
- Timeout and async reset: no ack for 64 cycles → fetch_err_o pulse, IDLE; assert rst mid-REQ → outputs 0 immediately, without waiting for a clock edge.
